updn_counter_param: RTL

Parametrised up/down counter, the next generation of the team's 16-bit load/up/down counter. Adds:
- configurable width and step size
- a runtime-programmable upper bound
- wrap or saturate behaviour at the bounds
- a terminal-count pulse and sticky overflow/underflow flags

Used wherever a bounded event or address counter is needed, for example buffer pointers and timer prescalers.

---
 rtl/updn_counter_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/updn_counter_param.sv
// updn_counter_param
//   Parametrised bounded up/down counter with parallel load, programmable
//   inclusive upper bound (lower bound fixed at 0), wrap or saturate at the
//   bounds, a one-cycle terminal-count pulse and sticky overflow/underflow
//   flags.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   STEP_W   width of the step input (1..WIDTH)
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bound
//
// Ports
//   clk        rising-edge clock
//   rst_       asynchronous active-low reset
//   data_in    parallel load value
//   ld_cnt     active-low synchronous load (highest priority)
//   updn_cnt   direction, 1 = up, 0 = down
//   count_enb  active-high count enable
//   step_in    amount added/subtracted per enabled cycle
//   max_val    inclusive upper bound, sampled every cycle
//   clr_flags  synchronous clear of the sticky flags
//   data_out   counter value (registered)
//   tc         terminal-count pulse (registered, one cycle per event)
//   ovf_flag   sticky overflow flag (registered)
//   unf_flag   sticky underflow flag (registered)
//   zero       combinational data_out == 0
module updn_counter_param #(
  parameter int WIDTH    = 16,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic [STEP_W-1:0] step_in,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf_flag,
  output logic              unf_flag,
  output logic              zero
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // One guard bit above the counter so an up-step past the all-ones value
  // is still seen as exceeding max_val instead of wrapping silently.
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff_w;

  logic do_count;
  logic ovf_evt;
  logic unf_evt;

  always_comb begin
    cnt_ext  = {1'b0, data_q};
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_in};
    max_ext  = {1'b0, max_val};
    sum_ext  = cnt_ext + step_ext;
    // Only used when step <= data_q, so the borrow bit is never needed.
    diff_w   = data_q - step_ext[WIDTH-1:0];

    // A zero step is a hold: no movement and no event.
    do_count = ld_cnt & count_enb & (|step_in);
    // A value already above max_val overflows on any up-step.
    ovf_evt  = do_count &  updn_cnt & (sum_ext > max_ext);
    unf_evt  = do_count & ~updn_cnt & (step_ext > cnt_ext);
  end

  always_comb begin
    data_d = data_q;
    if (!ld_cnt) begin
      data_d = data_in;
    end else if (do_count) begin
      if (updn_cnt) begin
        if (ovf_evt) data_d = (SATURATE != 0) ? max_val : '0;
        else         data_d = sum_ext[WIDTH-1:0];
      end else begin
        if (unf_evt) data_d = (SATURATE != 0) ? '0 : max_val;
        else         data_d = diff_w;
      end
    end

    tc_d  = ovf_evt | unf_evt;
    // An event in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_evt | (ovf_q & ~clr_flags);
    unf_d = unf_evt | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign data_out = data_q;
  assign tc       = tc_q;
  assign ovf_flag = ovf_q;
  assign unf_flag = unf_q;
  assign zero     = (data_q == '0);

endmodule
